soc_system_reset_btn: RTL and testbench
=======================================

# soc_system_reset_btn

Debounce and event-latch stage directly upstream of the one-bit `reset_cnt` input PIO. It takes the raw, asynchronous active-low counter-reset push-button and synchronizes and debounces it. It latches a qualified press into a sticky `reset_flag` that drives the PIO's `in_port`, and holds it until HPS software clears it through a small Avalon-MM slave. The slave also exposes a press counter and a runtime-programmable debounce threshold.

## Interface
- `CNT_W`, 16: width of debounce counter and threshold register.
- `DEB_CYCLES`, 50000: reset value of threshold (1 ms at 50 MHz).
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `btn_n` in 1: raw push-button, active low, asynchronous to `clk`.
- `address` in 2: Avalon-MM word address.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe, valid with `chipselect`.
- `writedata` in 32: write data.
- `readdata` out 32: registered read data.
- `reset_flag` out 1: sticky qualified-press flag, to PIO `in_port`.

## Operation
- **Synchronizer.** `btn_n` passes through 2 flops, reset to 1. Only the stage-2 output (`btn_s`) is used downstream.
- **FSM states:** IDLE, PRESS_DB, HELD, REL_DB. Reset state is IDLE with debounce counter `dcnt`=0.
  - IDLE: `btn_s`=0 -> PRESS_DB, `dcnt`=1.
  - PRESS_DB:
    - `btn_s`=1 -> IDLE, `dcnt`=0.
    - `btn_s`=0 and `dcnt`>=`thr_eff` -> HELD, set `reset_flag`, increment `evt_cnt`.
    - Otherwise `dcnt`++.
  - HELD: `btn_s`=1 -> REL_DB, `dcnt`=1.
  - REL_DB:
    - `btn_s`=0 -> HELD.
    - `btn_s`=1 and `dcnt`>=`thr_eff` -> IDLE.
    - Otherwise `dcnt`++.
  - Consequence: one press yields exactly one event. Bounce on release never produces a second event.
- **Threshold.** `thr_eff` = `thr`, or 1 when `thr`=0. `dcnt` saturates at all-ones and never wraps.
- **Threshold change mid-debounce.** The comparison uses the new value from the next cycle. If `dcnt` is already >= the new `thr_eff`, the FSM qualifies on that cycle.
- **Event counter.** `evt_cnt` is 8 bits and wraps 255 -> 0.
- **Register map** (access = `chipselect` & !`write_n` for writes, `chipselect` for reads):
  - Address 0, status, read-only: bit0 `reset_flag`, bit1 (state==HELD or REL_DB), bits 15:8 `evt_cnt`, all other bits 0.
  - Address 1, clear: write with `writedata[0]`=1 clears `reset_flag`. Writes with bit0=0 have no effect. Reads return 0.
  - Address 2, threshold: read/write `thr` on `writedata[CNT_W-1:0]`. Upper read bits are 0.
  - Address 3: reads 0, writes ignored.
- **Clear/set collision.** If a clear and a qualification occur on the same cycle, set wins and `reset_flag` stays 1.
- **Reset mid-operation.** Asserting `reset_n` at any time returns all state to reset values immediately, including a press in progress.

## Timing
- **Reset values:** `readdata`=0, `reset_flag`=0, `evt_cnt`=0, `thr`=`DEB_CYCLES`, state IDLE, synchronizer flops=1.
- **Press latency.** E1 is the first clock edge at which synchronizer stage 1 captures `btn_n`=0. The press must hold through sample edges E3..E(2+`thr_eff`). `reset_flag` reads 1 after E(2+`thr_eff`); it is a registered output with no combinational path.
- **Read latency.** `readdata` updates on every edge from the current `address` (registered mux, 1-cycle latency), regardless of `chipselect`.
- **Write latency.** Writes take effect on the edge where the strobe is sampled and are visible in `readdata` one edge later.

## Test plan
- **Clean press.** `thr`=4; hold `btn_n` low for 20 cycles, then high. Required: `reset_flag` rises after E6, `evt_cnt`=1, status reads 0x0000_0103 while held and 0x0000_0101 after release debounce.
- **Bounce rejection.** `thr`=4; pulse `btn_n` low for 3-cycle bursts separated by 1-cycle highs, 5 times. Required: `reset_flag` stays 0 and `evt_cnt`=0. Release bounce after a qualified press also yields `evt_cnt`=1, not 2.
- **Clear and collision.**
  - Write 1 to address 1 with the flag at 1. Required: status bit0=0 on the read issued next cycle.
  - Issue the clear write on the exact qualifying edge of a second press. Required: flag remains 1 and `evt_cnt`=2.
- **Wrap and zero threshold.** `thr`=0; apply 256 clean presses. Required: each qualifies after E3, and `evt_cnt` reads 0x00 after press 256.
- **Runtime threshold change.** `thr`=100; press; at `dcnt`=50 write `thr`=10. Required: `reset_flag` rises on the following edge.
- **Async reset.** Assert `reset_n` low in the middle of PRESS_DB and again while the flag is 1. Required: all outputs reset values immediately and `thr` reads back 50000 (0x0000_C350).

Source files
------------

// File: rtl/soc_system_reset_btn.sv
// Push-button debounce and sticky event latch for the counter-reset PIO input.
// Software reads status, clears the flag and tunes the debounce threshold over Avalon-MM.
module soc_system_reset_btn #(
    parameter int          CNT_W      = 16,
    parameter int unsigned DEB_CYCLES = 50000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        btn_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        reset_flag
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_REL_DB   = 2'd3;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] THR_RST = CNT_W'(DEB_CYCLES);

    logic             sync1_q, sync2_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [7:0]       evt_q, evt_d;
    logic             flag_q, flag_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             btn_s;
    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W-1:0] dcnt_inc;
    logic             one_sample;
    logic             qualify;
    logic             wr_en;
    logic             clr_req;

    assign btn_s = sync2_q;
    assign wr_en = chipselect & ~write_n;
    assign clr_req = wr_en && (address == 2'd1) && writedata[0];

    // dcnt holds samples already taken; the current edge's sample counts too,
    // so a press qualifies on the edge where the sample count reaches thr_eff.
    assign thr_eff    = (thr_q == '0) ? CNT_ONE : thr_q;
    assign dcnt_inc   = (&dcnt_q) ? dcnt_q : dcnt_q + CNT_ONE;
    assign one_sample = (thr_eff == CNT_ONE);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        dcnt_d  = dcnt_q;
        qualify = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!btn_s) begin
                    if (one_sample) begin
                        state_d = ST_HELD;
                        dcnt_d  = '0;
                        qualify = 1'b1;
                    end else begin
                        state_d = ST_PRESS_DB;
                        dcnt_d  = CNT_ONE;
                    end
                end
            end
            ST_PRESS_DB: begin
                if (btn_s) begin
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                end else if (dcnt_inc >= thr_eff) begin
                    state_d = ST_HELD;
                    dcnt_d  = '0;
                    qualify = 1'b1;
                end else begin
                    dcnt_d = dcnt_inc;
                end
            end
            ST_HELD: begin
                if (btn_s) begin
                    if (one_sample) begin
                        state_d = ST_IDLE;
                        dcnt_d  = '0;
                    end else begin
                        state_d = ST_REL_DB;
                        dcnt_d  = CNT_ONE;
                    end
                end
            end
            ST_REL_DB: begin
                if (!btn_s) begin
                    state_d = ST_HELD;
                    dcnt_d  = '0;
                end else if (dcnt_inc >= thr_eff) begin
                    state_d = ST_IDLE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_inc;
                end
            end
            default: begin
                state_d = ST_IDLE;
                dcnt_d  = '0;
            end
        endcase
    end

    // A qualification on the same edge as a software clear keeps the flag set.
    always_comb begin
        flag_d = flag_q;
        if (qualify)      flag_d = 1'b1;
        else if (clr_req) flag_d = 1'b0;
        evt_d = qualify ? evt_q + 8'd1 : evt_q;
        thr_d = (wr_en && (address == 2'd2)) ? writedata[CNT_W-1:0] : thr_q;
    end

    always_comb begin
        rdata_d = '0;
        case (address)
            2'd0: begin
                rdata_d[0]    = flag_q;
                rdata_d[1]    = (state_q == ST_HELD) || (state_q == ST_REL_DB);
                rdata_d[15:8] = evt_q;
            end
            2'd2:    rdata_d[CNT_W-1:0] = thr_q;
            default: rdata_d = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            state_q <= ST_IDLE;
            dcnt_q  <= '0;
            thr_q   <= THR_RST;
            evt_q   <= '0;
            flag_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            sync1_q <= btn_n;
            sync2_q <= sync1_q;
            state_q <= state_d;
            dcnt_q  <= dcnt_d;
            thr_q   <= thr_d;
            evt_q   <= evt_d;
            flag_q  <= flag_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata   = rdata_q;
    assign reset_flag = flag_q;

endmodule

// File: tb/tb_soc_system_reset_btn.sv
// Directed bench for soc_system_reset_btn: register-access vector table followed by
// hand-timed press, bounce, clear, collision, threshold, reset and wrap sequences.
module tb_soc_system_reset_btn;

    logic        clk;
    logic        reset_n;
    logic        btn_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        reset_flag;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        cs;
        logic        we;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [14];

    soc_system_reset_btn #(.CNT_W(16), .DEB_CYCLES(50000)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_n      (btn_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .reset_flag (reset_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not end, got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic reg_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
    endtask

    task automatic reg_read(input logic [1:0] a, output logic [31:0] rd);
        address    = a;
        chipselect = 1'b1;
        step();
        rd         = readdata;
        chipselect = 1'b0;
        address    = 2'd0;
    endtask

    initial begin
        logic [31:0] rd;

        //             cs    we    addr   wdata          expected readdata
        vecs[0]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h0000_0000};
        vecs[1]  = '{1'b1, 1'b0, 2'd1, 32'h0,         32'h0000_0000};
        vecs[2]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0000_C350};
        vecs[3]  = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h0000_0000};
        vecs[4]  = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5]  = '{1'b1, 1'b0, 2'd3, 32'h0,         32'h0000_0000};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 32'hDEAD_1234, 32'h0000_C350};
        vecs[7]  = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0000_1234};
        vecs[8]  = '{1'b1, 1'b1, 2'd1, 32'h0000_0000, 32'h0000_0000};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 32'h0,         32'h0000_0000};
        vecs[10] = '{1'b0, 1'b1, 2'd2, 32'h0000_5555, 32'h0000_1234};
        vecs[11] = '{1'b0, 1'b0, 2'd2, 32'h0,         32'h0000_1234};
        vecs[12] = '{1'b1, 1'b1, 2'd2, 32'h0000_0004, 32'h0000_1234};
        vecs[13] = '{1'b1, 1'b0, 2'd2, 32'h0,         32'h0000_0004};

        reset_n    = 1'b0;
        btn_n      = 1'b1;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        @(negedge clk);
        @(negedge clk);
        check("reset readdata", readdata, 32'h0);
        check("reset flag", 32'(reset_flag), 32'h0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 14; i++) begin
            chipselect = vecs[i].cs;
            write_n    = ~vecs[i].we;
            address    = vecs[i].addr;
            writedata  = vecs[i].wdata;
            step();
            check($sformatf("vector %0d readdata", i), readdata, vecs[i].exp_rd);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;

        // Bounce rejection, thr=4: three low samples never reach four.
        for (int b = 0; b < 5; b++) begin
            btn_n = 1'b0;
            repeat (3) step();
            btn_n = 1'b1;
            step();
        end
        repeat (5) step();
        check("bounce flag", 32'(reset_flag), 32'h0);
        check("bounce status", readdata, 32'h0000_0000);

        // Clean press, thr=4: flag rises after E6.
        btn_n = 1'b0;
        for (int e = 1; e <= 6; e++) begin
            step();
            if (e == 5) check("press flag E5", 32'(reset_flag), 32'h0);
            if (e == 6) check("press flag E6", 32'(reset_flag), 32'h1);
        end
        step();
        check("held status", readdata, 32'h0000_0103);
        repeat (13) step();
        btn_n = 1'b1; step();
        btn_n = 1'b0; step();
        btn_n = 1'b1; step();
        btn_n = 1'b0; step();
        btn_n = 1'b1;
        repeat (10) step();
        check("released status", readdata, 32'h0000_0101);

        // Software clear.
        reg_write(2'd1, 32'h1);
        step();
        check("clear flag", 32'(reset_flag), 32'h0);
        check("clear status", readdata, 32'h0000_0100);

        // Clear write on the qualifying edge E6 of a second press.
        btn_n = 1'b0;
        repeat (5) step();
        address    = 2'd1;
        writedata  = 32'h1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        check("collision flag", 32'(reset_flag), 32'h1);
        step();
        check("collision status", readdata, 32'h0000_0203);
        btn_n = 1'b1;
        repeat (10) step();
        reg_write(2'd1, 32'h1);
        step();
        check("collision cleared", readdata, 32'h0000_0200);

        // Threshold 100 lowered to 10 at dcnt=50 (the edge E53).
        reg_write(2'd2, 32'd100);
        btn_n = 1'b0;
        repeat (52) step();
        reg_write(2'd2, 32'd10);
        check("thr change flag E53", 32'(reset_flag), 32'h0);
        step();
        check("thr change flag E54", 32'(reset_flag), 32'h1);
        btn_n = 1'b1;
        repeat (20) step();
        check("thr change status", readdata, 32'h0000_0301);
        reg_write(2'd1, 32'h1);

        // Asynchronous reset inside PRESS_DB, then again with the flag set.
        btn_n = 1'b0;
        repeat (5) step();
        check("pre-reset status", readdata, 32'h0000_0300);
        reset_n = 1'b0;
        btn_n   = 1'b1;
        #1;
        check("async reset readdata", readdata, 32'h0);
        check("async reset flag", 32'(reset_flag), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        reg_read(2'd2, rd);
        check("thr after reset", rd, 32'h0000_C350);
        reg_read(2'd0, rd);
        check("status after reset", rd, 32'h0000_0000);
        reg_write(2'd2, 32'd2);
        btn_n = 1'b0;
        repeat (4) step();
        check("flag before 2nd reset", 32'(reset_flag), 32'h1);
        reset_n = 1'b0;
        btn_n   = 1'b1;
        #1;
        check("2nd reset readdata", readdata, 32'h0);
        check("2nd reset flag", 32'(reset_flag), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        reg_read(2'd2, rd);
        check("thr after 2nd reset", rd, 32'h0000_C350);
        reg_read(2'd0, rd);
        check("status after 2nd reset", rd, 32'h0000_0000);

        // Zero threshold behaves as one sample; 256 presses wrap the counter.
        reg_write(2'd2, 32'd0);
        for (int p = 1; p <= 256; p++) begin
            reg_write(2'd1, 32'h1);
            btn_n = 1'b0;
            step();
            step();
            check($sformatf("wrap press %0d E2", p), 32'(reset_flag), 32'h0);
            step();
            check($sformatf("wrap press %0d E3", p), 32'(reset_flag), 32'h1);
            btn_n = 1'b1;
            repeat (4) step();
            if (p == 255) begin
                reg_read(2'd0, rd);
                check("status after 255 presses", rd, 32'h0000_FF01);
            end
        end
        reg_read(2'd0, rd);
        check("status after 256 presses", rd, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
